dram_slv: RTL

DRAM_SLV -- requirements
Module: dram_slv

---
 rtl/dram_slv.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dram_slv.sv
// dram_slv: single-outstanding 32-bit SRAM responder with a valid/ready
// command channel and a valid/ready response channel.
//
// A command is accepted in cycle N. The RAM is accessed at the clock edge
// that ends cycle N, and the response is presented in cycle N+1. A new
// command can be accepted in the same cycle that the current response is
// consumed, so the block sustains one transfer per cycle.
//
// The storage is split into NUM_LANES byte lanes (dram_slv_lane). Each lane
// has its own write enable taken from the byte write mask.
//
// Parameters
//   DEPTH_LOG2      word-address width (default 4096 words)
//   BASE_ADDR       byte address of word 0
// Optional macro
//   DRAM_ERR_CHK_EN flags out-of-window accesses. The flagged access does not
//                   write and returns rdata=0. Without this macro, addresses
//                   outside the window alias onto the RAM through the index
//                   bits, and dram_rsp_error is tied to 0.
// Ports
//   clk, rst_n                            clock, async active-low reset
//   dram_cmd_valid/ready                  command handshake
//   dram_cmd_addr/we/wem/wdata            byte address, write flag, byte mask, data
//   dram_rsp_valid/ready                  response handshake
//   dram_rsp_rdata/error                  read data (0 for writes), error flag

// One byte lane. The RAM array has no reset. Only the read register is reset.
module dram_slv_lane #(
   parameter int DEPTH_LOG2 = 12,
   parameter int VEC_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  clr,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [VEC_W-1:0]      wdata,
   output logic [VEC_W-1:0]      rdata
);
   logic [VEC_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk)
      if (wr_en) mem[idx] <= wdata;

   // The read register is loaded only on an accepted read. It holds its
   // value through a response stall, and it is cleared for write or error
   // responses.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)     rdata <= '0;
      else if (rd_en) rdata <= mem[idx];
      else if (clr)   rdata <= '0;
endmodule

module dram_slv #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dram_cmd_valid,
   output logic        dram_cmd_ready,
   input  logic [31:0] dram_cmd_addr,
   input  logic        dram_cmd_we,
   input  logic [3:0]  dram_cmd_wem,
   input  logic [31:0] dram_cmd_wdata,
   output logic        dram_rsp_valid,
   input  logic        dram_rsp_ready,
   output logic [31:0] dram_rsp_rdata,
   output logic        dram_rsp_error
);
   localparam int NUM_LANES = 4;
   localparam int VEC_W     = 8;

   typedef enum logic {IDLE, RESP} state_t;
   state_t state, state_nxt;

   logic                               hs;
   logic                               in_range;
   logic [31:0]                        off;
   logic [DEPTH_LOG2-1:0]              idx;
   logic [NUM_LANES-1:0][VEC_W-1:0]    wd;
   logic [NUM_LANES-1:0][VEC_W-1:0]    rd_lane;
   logic                               unused_ok;

   assign dram_rsp_valid = (state == RESP);
   assign dram_cmd_ready = (state == IDLE) | (dram_rsp_valid & dram_rsp_ready);
   assign hs             = dram_cmd_valid & dram_cmd_ready;

   assign off = dram_cmd_addr - BASE_ADDR;
   assign idx = off[DEPTH_LOG2+1:2];
   assign wd  = dram_cmd_wdata;

`ifdef DRAM_ERR_CHK_EN
   // The unsigned offset wraps for addresses below BASE_ADDR. Any set bit
   // above the window therefore means the address is out of range.
   assign in_range = (off[31:DEPTH_LOG2+2] == '0);
`else
   assign in_range = 1'b1;
`endif

   // The byte-offset bits, and (in the default build) the upper offset
   // bits, intentionally have no other use.
   assign unused_ok = &{1'b0, off[1:0], off[31:DEPTH_LOG2+2]};

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      dram_slv_lane #(.DEPTH_LOG2(DEPTH_LOG2), .VEC_W(VEC_W)) u_lane (
         .clk   (clk),
         .rst_n (rst_n),
         .wr_en (hs & dram_cmd_we & dram_cmd_wem[l] & in_range),
         .rd_en (hs & ~dram_cmd_we & in_range),
         .clr   (hs & (dram_cmd_we | ~in_range)),
         .idx   (idx),
         .wdata (wd[l]),
         .rdata (rd_lane[l])
      );
   end

   assign dram_rsp_rdata = rd_lane;

`ifdef DRAM_ERR_CHK_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)  err_q <= 1'b0;
      else if (hs) err_q <= ~in_range;
   assign dram_rsp_error = err_q;
`else
   assign dram_rsp_error = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (hs) state_nxt = RESP;
         RESP: if (hs) state_nxt = RESP;
               else if (dram_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule
